// File: rtl/reorder_buffer_param_pkg.sv
// rtl/reorder_buffer_param_pkg.sv - shared types and constants for the reorder buffer
package reorder_buffer_param_pkg;

  localparam int ARCH_W = 5;
  localparam int PC_W   = 64;

  localparam logic [PC_W-1:0] TRAP_VEC_DEFAULT = 64'h0000_0000_0000_0100;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

  typedef struct packed {
    logic done;
    logic exc;
    logic mispred;
  } rob_flags_t;

  localparam int FLAGS_W = $bits(rob_flags_t);

endpackage

// File: rtl/rob_entry_array.sv
// rtl/rob_entry_array.sv - reorder buffer entry storage: alloc write, wb flag write, head read
module rob_entry_array
  import reorder_buffer_param_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc_en,
  input  logic [TAG_W-1:0]  i_alloc_idx,
  input  logic [ARCH_W-1:0] i_alloc_arch,
  input  logic [PREG_W-1:0] i_alloc_phys,
  input  logic [PREG_W-1:0] i_alloc_old,
  input  logic [PC_W-1:0]   i_alloc_pc,
  input  logic              i_wb_en,
  input  logic [TAG_W-1:0]  i_wb_idx,
  input  logic              i_wb_exc,
  input  logic              i_wb_mispred,
  input  logic [PC_W-1:0]   i_wb_target,
  input  logic              i_flush,
  input  logic [TAG_W-1:0]  i_head_idx,
  output rob_flags_t        o_head_flags,
  output logic [ARCH_W-1:0] o_head_arch,
  output logic [PREG_W-1:0] o_head_phys,
  output logic [PREG_W-1:0] o_head_old,
  output logic [PC_W-1:0]   o_head_pc,
  output logic [PC_W-1:0]   o_head_target
);

  logic [ARCH_W-1:0] r_arch   [DEPTH];
  logic [PREG_W-1:0] r_phys   [DEPTH];
  logic [PREG_W-1:0] r_old    [DEPTH];
  logic [PC_W-1:0]   r_pc     [DEPTH];
  logic [PC_W-1:0]   r_target [DEPTH];
  rob_flags_t        r_flags  [DEPTH];

  // Payload needs no reset: it is only observed once an entry is allocated.
  always_ff @(posedge clk) begin
    if (i_alloc_en) begin
      r_arch[i_alloc_idx] <= i_alloc_arch;
      r_phys[i_alloc_idx] <= i_alloc_phys;
      r_old[i_alloc_idx]  <= i_alloc_old;
      r_pc[i_alloc_idx]   <= i_alloc_pc;
    end
    if (i_wb_en) begin
      r_target[i_wb_idx] <= i_wb_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_flags[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_flags[i] <= '0;
    end else begin
      if (i_alloc_en) r_flags[i_alloc_idx] <= '0;
      if (i_wb_en)    r_flags[i_wb_idx]    <= '{done: 1'b1, exc: i_wb_exc, mispred: i_wb_mispred};
    end
  end

  assign o_head_flags  = r_flags[i_head_idx];
  assign o_head_arch   = r_arch[i_head_idx];
  assign o_head_phys   = r_phys[i_head_idx];
  assign o_head_old    = r_old[i_head_idx];
  assign o_head_pc     = r_pc[i_head_idx];
  assign o_head_target = r_target[i_head_idx];

endmodule

// File: rtl/reorder_buffer_param.sv
// rtl/reorder_buffer_param.sv - in-order retirement reorder buffer with mispredict/exception flush
module reorder_buffer_param
  import reorder_buffer_param_pkg::*;
#(
  parameter int              DEPTH    = 16,
  parameter int              PREG_W   = 6,
  parameter logic [PC_W-1:0] TRAP_VEC = TRAP_VEC_DEFAULT,
  localparam int             TAG_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [ARCH_W-1:0] alloc_arch_dest,
  input  logic [PREG_W-1:0] alloc_phys_dest,
  input  logic [PREG_W-1:0] alloc_old_phys,
  input  logic [PC_W-1:0]   alloc_pc,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              wb_exception,
  input  logic              wb_mispredict,
  input  logic [PC_W-1:0]   wb_target,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [ARCH_W-1:0] commit_arch_dest,
  output logic [PREG_W-1:0] commit_phys_dest,
  output logic [PREG_W-1:0] commit_old_phys,
  output logic [PC_W-1:0]   commit_pc,
  output logic              flush_valid,
  output logic [PC_W-1:0]   flush_pc,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  rob_state_e        r_state, w_state_nxt;
  logic [TAG_W:0]    r_head, r_tail, w_head_nxt, w_count;
  logic [PC_W-1:0]   r_flush_pc;
  logic              w_run, w_empty, w_full, w_alloc, w_retire;
  logic              w_exc_flush, w_mis_flush, w_start_flush, w_wb_hit;
  logic [TAG_W-1:0]  w_wb_off;
  rob_flags_t        w_head_flags;
  logic [ARCH_W-1:0] w_head_arch;
  logic [PREG_W-1:0] w_head_phys, w_head_old;
  logic [PC_W-1:0]   w_head_pc, w_head_target;

  assign w_count = r_tail - r_head;
  assign w_empty = (r_tail == r_head);
  assign w_full  = (r_tail[TAG_W-1:0] == r_head[TAG_W-1:0]) && (r_tail[TAG_W] != r_head[TAG_W]);
  assign w_run   = (r_state == ST_RUN);

  assign alloc_ready  = w_run && !w_full;
  assign w_alloc      = alloc_valid && alloc_ready;
  assign commit_valid = w_run && !w_empty && w_head_flags.done && !w_head_flags.exc;
  assign w_retire     = commit_valid && commit_ready;
  assign w_exc_flush  = w_run && !w_empty && w_head_flags.done && w_head_flags.exc;
  assign w_mis_flush  = w_retire && w_head_flags.mispred;
  assign w_head_nxt   = r_head + {{TAG_W{1'b0}}, w_retire};

  // A writeback is accepted only if its tag lies within the occupied window [head, tail).
  assign w_wb_off = wb_tag - r_head[TAG_W-1:0];
  assign w_wb_hit = wb_valid && w_run && ({1'b0, w_wb_off} < w_count);

  always_comb begin
    w_state_nxt   = r_state;
    w_start_flush = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_exc_flush || w_mis_flush) begin
          w_state_nxt   = ST_FLUSH;
          w_start_flush = 1'b1;
        end
      end
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Squash happens on entry to FLUSH so the flush cycle already sees an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_head     <= '0;
      r_tail     <= '0;
      r_flush_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      if (w_start_flush) begin
        r_tail     <= w_head_nxt;
        r_flush_pc <= w_mis_flush ? w_head_target : TRAP_VEC;
      end else begin
        r_tail <= r_tail + {{TAG_W{1'b0}}, w_alloc};
      end
    end
  end

  rob_entry_array #(
    .DEPTH  (DEPTH),
    .PREG_W (PREG_W)
  ) u_entries (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_alloc_en    (w_alloc && !w_start_flush),
    .i_alloc_idx   (r_tail[TAG_W-1:0]),
    .i_alloc_arch  (alloc_arch_dest),
    .i_alloc_phys  (alloc_phys_dest),
    .i_alloc_old   (alloc_old_phys),
    .i_alloc_pc    (alloc_pc),
    .i_wb_en       (w_wb_hit),
    .i_wb_idx      (wb_tag),
    .i_wb_exc      (wb_exception),
    .i_wb_mispred  (wb_mispredict),
    .i_wb_target   (wb_target),
    .i_flush       (w_start_flush),
    .i_head_idx    (r_head[TAG_W-1:0]),
    .o_head_flags  (w_head_flags),
    .o_head_arch   (w_head_arch),
    .o_head_phys   (w_head_phys),
    .o_head_old    (w_head_old),
    .o_head_pc     (w_head_pc),
    .o_head_target (w_head_target)
  );

  assign alloc_tag        = r_tail[TAG_W-1:0];
  assign commit_arch_dest = w_empty ? '0 : w_head_arch;
  assign commit_phys_dest = w_empty ? '0 : w_head_phys;
  assign commit_old_phys  = w_empty ? '0 : w_head_old;
  assign commit_pc        = w_empty ? '0 : w_head_pc;
  assign flush_valid      = (r_state == ST_FLUSH);
  assign flush_pc         = r_flush_pc;
  assign count            = w_count;
  assign empty            = w_empty;
  assign full             = w_full;

endmodule

// File: tb/tb_reorder_buffer_param.sv
// tb/tb_reorder_buffer_param.sv - self-checking bench for reorder_buffer_param
module tb_reorder_buffer_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0, alloc_ready;
  logic [4:0]  alloc_arch_dest = '0;
  logic [5:0]  alloc_phys_dest = '0, alloc_old_phys = '0;
  logic [63:0] alloc_pc = '0;
  logic [3:0]  alloc_tag;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_tag = '0;
  logic        wb_exception = 1'b0, wb_mispredict = 1'b0;
  logic [63:0] wb_target = '0;
  logic        commit_valid, commit_ready = 1'b0;
  logic [4:0]  commit_arch_dest;
  logic [5:0]  commit_phys_dest, commit_old_phys;
  logic [63:0] commit_pc;
  logic        flush_valid;
  logic [63:0] flush_pc;
  logic [4:0]  count;
  logic        empty, full;

  reorder_buffer_param dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_arch_dest(alloc_arch_dest), .alloc_phys_dest(alloc_phys_dest),
    .alloc_old_phys(alloc_old_phys), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exception(wb_exception),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_arch_dest(commit_arch_dest), .commit_phys_dest(commit_phys_dest),
    .commit_old_phys(commit_old_phys), .commit_pc(commit_pc),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [4:0]  arch;
    logic [5:0]  phys;
    logic [5:0]  old;
    logic [63:0] pc;
    bit          done;
    bit          exc;
    bit          mis;
    logic [63:0] tgt;
  } ent_t;

  ent_t        q[$];
  int          m_head, m_tail;
  bit          m_fl;
  logic [63:0] m_fpc;
  int          n_chk = 0, n_err = 0;
  int          k = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_head = 0;
    m_tail = 0;
    m_fl   = 0;
    m_fpc  = '0;
  endtask

  task automatic compare();
    int n = q.size();
    bit hv = (n > 0);
    chk("alloc_ready", alloc_ready, 64'(!m_fl && n < 16));
    chk("alloc_tag", alloc_tag, 64'(m_tail % 16));
    chk("commit_valid", commit_valid, 64'(!m_fl && hv && q[0].done && !q[0].exc));
    chk("commit_arch", commit_arch_dest, hv ? 64'(q[0].arch) : 64'd0);
    chk("commit_phys", commit_phys_dest, hv ? 64'(q[0].phys) : 64'd0);
    chk("commit_old", commit_old_phys, hv ? 64'(q[0].old) : 64'd0);
    chk("commit_pc", commit_pc, hv ? q[0].pc : 64'd0);
    chk("flush_valid", flush_valid, 64'(m_fl));
    chk("flush_pc", flush_pc, m_fpc);
    chk("count", count, 64'(n));
    chk("empty", empty, 64'(n == 0));
    chk("full", full, 64'(n == 16));
  endtask

  task automatic m_update();
    int n = q.size();
    bit cv, ret, excf, misf;
    logic [63:0] tgt = '0;
    ent_t e;
    if (m_fl) begin
      m_fl = 0;
      return;
    end
    cv   = n > 0 && q[0].done && !q[0].exc;
    ret  = cv && commit_ready;
    excf = n > 0 && q[0].done && q[0].exc;
    misf = ret && q[0].mis;
    if (n > 0) tgt = q[0].tgt;
    if (wb_valid)
      foreach (q[i])
        if (q[i].tag == int'(wb_tag)) begin
          q[i].done = 1; q[i].exc = wb_exception; q[i].mis = wb_mispredict; q[i].tgt = wb_target;
        end
    if (alloc_valid && n < 16) begin
      e = '{tag: m_tail % 16, arch: alloc_arch_dest, phys: alloc_phys_dest, old: alloc_old_phys,
            pc: alloc_pc, done: 0, exc: 0, mis: 0, tgt: '0};
      q.push_back(e);
      m_tail++;
    end
    if (ret) begin
      void'(q.pop_front());
      m_head++;
    end
    if (excf || misf) begin
      q.delete();
      m_tail = m_head;
      m_fl   = 1;
      m_fpc  = misf ? tgt : 64'h100;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst_n) m_reset();
    compare();
    @(posedge clk);
    if (rst_n) m_update();
    #1;
  endtask

  task automatic idle_in();
    alloc_valid   = 0;
    wb_valid      = 0;
    wb_exception  = 0;
    wb_mispredict = 0;
    wb_target     = '0;
  endtask

  task automatic set_alloc();
    alloc_valid     = 1;
    alloc_arch_dest = 5'(k);
    alloc_phys_dest = 6'(k + 7);
    alloc_old_phys  = ~6'(k);
    alloc_pc        = 64'h1000 + 64'(4 * k);
    k++;
  endtask

  task automatic set_wb(input int t, input bit ex, input bit mp, input logic [63:0] tg);
    wb_valid      = 1;
    wb_tag        = 4'(t);
    wb_exception  = ex;
    wb_mispredict = mp;
    wb_target     = tg;
  endtask

  logic [63:0] pcb;

  initial begin
    m_reset();
    repeat (3) step();
    chk("rst alloc_ready", alloc_ready, 1);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    rst_n = 1;

    // fill all 16 without commit
    for (int i = 0; i < 16; i++) begin
      set_alloc();
      chk("fill tag", alloc_tag, 64'(i));
      step();
    end
    idle_in();
    chk("full flag", full, 1);
    chk("full alloc_ready", alloc_ready, 0);
    chk("full count", count, 16);
    set_alloc();
    step();
    idle_in();
    commit_ready = 1;
    for (int i = 0; i < 16; i++) begin
      set_wb(i, 0, 0, '0);
      step();
    end
    idle_in();
    repeat (2) step();
    chk("drain count", count, 0);

    // out-of-order completion, in-order retire
    pcb = 64'h1000 + 64'(4 * k);
    repeat (3) begin set_alloc(); step(); end
    idle_in();
    set_wb(2, 0, 0, '0); step();
    set_wb(0, 0, 0, '0); step();
    idle_in();
    chk("ooo cv0", commit_valid, 1);
    chk("ooo pc0", commit_pc, pcb);
    step();
    chk("ooo block", commit_valid, 0);
    chk("ooo pc1 wait", commit_pc, pcb + 4);
    set_wb(1, 0, 0, '0); step();
    idle_in();
    chk("ooo cv1", commit_valid, 1);
    chk("ooo pc1", commit_pc, pcb + 4);
    step();
    chk("ooo pc2", commit_pc, pcb + 8);
    step();
    chk("ooo count", count, 0);

    // mispredict with younger alloc squashed
    set_alloc(); step();
    idle_in();
    set_wb(3, 0, 1, 64'h2000); step();
    idle_in();
    set_alloc(); step();
    idle_in();
    chk("mis flush_valid", flush_valid, 1);
    chk("mis flush_pc", flush_pc, 64'h2000);
    chk("mis count", count, 0);
    chk("mis alloc_ready", alloc_ready, 0);
    chk("mis commit_valid", commit_valid, 0);
    step();
    chk("mis after flush", flush_valid, 0);
    chk("mis tail=head", alloc_tag, 4);

    // exception at head
    set_alloc(); step();
    set_alloc(); step();
    idle_in();
    set_wb(4, 1, 0, '0); step();
    idle_in();
    chk("exc no commit", commit_valid, 0);
    step();
    chk("exc flush_valid", flush_valid, 1);
    chk("exc flush_pc", flush_pc, 64'h100);
    chk("exc head kept", alloc_tag, 4);
    chk("exc count", count, 0);
    step();

    // steady alloc + commit across two wraps
    for (int c = 0; c < 40; c++) begin
      set_alloc();
      if (c > 0) set_wb((m_tail - 1) % 16, 0, 0, '0);
      else wb_valid = 0;
      if (c == 20) chk("steady count", count, 2);
      step();
    end
    idle_in();
    chk("steady end count", count, 2);
    set_wb((m_tail - 1) % 16, 0, 0, '0); step();
    idle_in();
    repeat (3) step();

    // reset with entries pending
    commit_ready = 0;
    repeat (5) begin set_alloc(); step(); end
    idle_in();
    rst_n = 0;
    #1;
    chk("arst alloc_ready", alloc_ready, 1);
    chk("arst alloc_tag", alloc_tag, 0);
    chk("arst commit_valid", commit_valid, 0);
    chk("arst commit_pc", commit_pc, 0);
    chk("arst commit_arch", commit_arch_dest, 0);
    chk("arst flush_valid", flush_valid, 0);
    chk("arst flush_pc", flush_pc, 0);
    chk("arst count", count, 0);
    chk("arst empty", empty, 1);
    chk("arst full", full, 0);
    m_reset();
    repeat (2) step();
    rst_n = 1;

    // reset in the middle of FLUSH
    set_alloc(); step();
    idle_in();
    set_wb(0, 1, 0, '0); step();
    idle_in();
    step();
    chk("fl pre-reset", flush_valid, 1);
    rst_n = 0;
    #1;
    chk("fl arst flush_valid", flush_valid, 0);
    chk("fl arst flush_pc", flush_pc, 0);
    chk("fl arst alloc_ready", alloc_ready, 1);
    m_reset();
    step();
    rst_n = 1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
